// File: rtl/alu_result_capture.sv
// Two-entry skid buffer that captures ALU results and presents the head as the Z register pair.
// Optional Z_FLAGS_EN macro adds per-entry zero/negative/wide flags that follow the head.
module alu_result_capture #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_lo,
   input  logic [DATA_W-1:0] in_hi,
   input  logic              in_wide,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] z_high,
   output logic [DATA_W-1:0] z_low,
   output logic [1:0]        count
`ifdef Z_FLAGS_EN
   ,
   output logic              flag_zero,
   output logic              flag_neg,
   output logic              flag_wide
`endif
);

   generate
      if (DEPTH != 2) begin : g_depth_check
         $error("alu_result_capture: only DEPTH=2 is supported");
      end
   endgenerate

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic              push, pop;
   logic              head_ld_in, head_ld_skid, skid_ld;
   logic [DATA_W-1:0] cap_hi;
   logic [DATA_W-1:0] head_hi, head_lo, skid_hi, skid_lo;

   assign push   = in_valid && (state != FULL);
   assign pop    = out_ready && (state != EMPTY);
   assign cap_hi = in_wide ? in_hi : '0;

   always_ff @(posedge clock) begin
      if (clear) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      head_ld_in   = 1'b0;
      head_ld_skid = 1'b0;
      skid_ld      = 1'b0;
      in_ready     = (state != FULL);
      out_valid    = (state != EMPTY);
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt  = ONE;
               head_ld_in = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_ld_in = 1'b1;
            end else if (push) begin
               state_nxt = FULL;
               skid_ld   = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt    = ONE;
               head_ld_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Head keeps its value on a pop-to-empty so z_* show the last popped result.
   always_ff @(posedge clock) begin
      if (clear) begin
         head_hi <= '0;
         head_lo <= '0;
         skid_hi <= '0;
         skid_lo <= '0;
      end else begin
         if (head_ld_in) begin
            head_hi <= cap_hi;
            head_lo <= in_lo;
         end else if (head_ld_skid) begin
            head_hi <= skid_hi;
            head_lo <= skid_lo;
         end
         if (skid_ld) begin
            skid_hi <= cap_hi;
            skid_lo <= in_lo;
         end
      end
   end

   assign z_high = head_hi;
   assign z_low  = head_lo;
   assign count  = state;

`ifdef Z_FLAGS_EN
   logic [2:0] cap_f, head_f, skid_f;

   // Flag order: {zero, neg, wide}.
   assign cap_f = {(in_lo == '0) && (!in_wide || (in_hi == '0)),
                   in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1],
                   in_wide};

   always_ff @(posedge clock) begin
      if (clear) begin
         head_f <= '0;
         skid_f <= '0;
      end else begin
         if (head_ld_in)        head_f <= cap_f;
         else if (head_ld_skid) head_f <= skid_f;
         if (skid_ld)           skid_f <= cap_f;
      end
   end

   assign flag_zero = head_f[2];
   assign flag_neg  = head_f[1];
   assign flag_wide = head_f[0];
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Randomized self-checking bench for alu_result_capture against a queue-based reference model.
// Build with +define+Z_FLAGS_EN to also check the optional flag outputs.
module tb_alu_result_capture;

   logic        clock;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_lo;
   logic [31:0] in_hi;
   logic        in_wide;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] z_high;
   logic [31:0] z_low;
   logic [1:0]  count;
`ifdef Z_FLAGS_EN
   logic        flag_zero, flag_neg, flag_wide;
`endif

   alu_result_capture #(.DATA_W(32), .DEPTH(2)) dut (
      .clock     (clock),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lo     (in_lo),
      .in_hi     (in_hi),
      .in_wide   (in_wide),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z_high    (z_high),
      .z_low     (z_low),
      .count     (count)
`ifdef Z_FLAGS_EN
      ,
      .flag_zero (flag_zero),
      .flag_neg  (flag_neg),
      .flag_wide (flag_wide)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        wide;
   } ent_t;

   ent_t        q[$];
   logic [63:0] sent[$];
   logic [63:0] rx[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        last_push;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model by the handshake rules, compare after the edge.
   task automatic step(input logic clr, input logic iv, input logic [31:0] lo,
                       input logic [31:0] hi, input logic wd, input logic orr);
      logic m_push, m_pop;
      ent_t e;
      clear     = clr;
      in_valid  = iv;
      in_lo     = lo;
      in_hi     = hi;
      in_wide   = wd;
      out_ready = orr;
      m_push = !clr && iv && (q.size() != 2);
      m_pop  = !clr && orr && (q.size() != 0);
      if (!clr && out_valid && orr) rx.push_back({z_high, z_low});
      @(posedge clock);
      #1;
      last_push = m_push;
      if (clr) begin
         q.delete();
      end else begin
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            e.hi   = wd ? hi : 32'h0;
            e.lo   = lo;
            e.wide = wd;
            q.push_back(e);
         end
      end
      check("count", 64'(count), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() != 2));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("z_high", 64'(z_high), 64'(q[0].hi));
         check("z_low", 64'(z_low), 64'(q[0].lo));
`ifdef Z_FLAGS_EN
         check("flag_zero", 64'(flag_zero),
               64'(q[0].lo == 0 && (!q[0].wide || q[0].hi == 0)));
         check("flag_neg", 64'(flag_neg),
               64'(q[0].wide ? q[0].hi[31] : q[0].lo[31]));
         check("flag_wide", 64'(flag_wide), 64'(q[0].wide));
`endif
      end
   endtask

   initial begin
      logic [31:0] c_lo, c_hi;
      logic        c_wd, iv, orr;
      int          n_sent, cyc;

      clear = 1'b1; in_valid = 1'b0; in_lo = '0; in_hi = '0; in_wide = 1'b0; out_ready = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      check("rst_zh", 64'(z_high), 64'h0);
      check("rst_zl", 64'(z_low), 64'h0);
`ifdef Z_FLAGS_EN
      check("rst_flags", 64'({flag_zero, flag_neg, flag_wide}), 64'h0);
`endif

      // ASR result, narrow, stale in_hi must not leak
      step(0, 1, 32'hF8000000, 32'hDEADBEEF, 0, 1);
      check("asr_zl", 64'(z_low), 64'hF8000000);
      check("asr_zh", 64'(z_high), 64'h0);
`ifdef Z_FLAGS_EN
      check("asr_neg", 64'(flag_neg), 64'h1);
      check("asr_zero", 64'(flag_zero), 64'h0);
`endif
      step(0, 0, 0, 0, 0, 1);
      check("asr_drained", 64'(count), 64'h0);

      // Back-pressure fill; third value must be dropped
      step(0, 1, 32'h1, 0, 0, 0);
      step(0, 1, 32'h2, 0, 0, 0);
      step(0, 1, 32'h3, 0, 0, 0);
      check("bp_full", 64'({count, in_ready}), 64'({2'd2, 1'b0}));
      step(0, 0, 0, 0, 0, 1);
      check("bp_pop1_ready", 64'(in_ready), 64'h1);
      check("bp_head2", 64'(z_low), 64'h2);
      step(0, 0, 0, 0, 0, 1);

      // Simultaneous push/pop at count=1
      step(0, 1, 32'hAAAA0000, 0, 0, 0);
      step(0, 1, 32'h0000BBBB, 0, 0, 1);
      check("pp_count", 64'(count), 64'h1);
      check("pp_head", 64'(z_low), 64'h0000BBBB);
      step(0, 0, 0, 0, 0, 1);

      // Wide zero, then wide with negative high word
      step(0, 1, 32'h0, 32'h0, 1, 1);
      check("wz_z", 64'({z_high, z_low}), 64'h0);
`ifdef Z_FLAGS_EN
      check("wz_flags", 64'({flag_zero, flag_wide}), 64'h3);
`endif
      step(0, 1, 32'h0, 32'h80000000, 1, 1);
`ifdef Z_FLAGS_EN
      check("wn_neg", 64'(flag_neg), 64'h1);
`endif
      step(0, 0, 0, 0, 0, 1);

      // Clear while full with push and pop requested
      step(0, 1, 32'h11, 32'h22, 1, 0);
      step(0, 1, 32'h33, 32'h44, 1, 0);
      step(1, 1, 32'h55, 32'h66, 1, 1);
      check("mid_clr_z", 64'({z_high, z_low}), 64'h0);
      check("mid_clr_st", 64'({count, out_valid, in_ready}), 64'({2'd0, 1'b0, 1'b1}));

      // Random producer/consumer stalls
      sent.delete();
      rx.delete();
      n_sent = 0;
      cyc = 0;
      c_lo = $urandom; c_hi = $urandom; c_wd = 1'($urandom_range(0, 1));
      while (n_sent < 1000 && cyc < 20000) begin
         iv  = ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 2) != 0);
         step(0, iv, c_lo, c_hi, c_wd, orr);
         cyc++;
         if (last_push) begin
            sent.push_back({c_wd ? c_hi : 32'h0, c_lo});
            n_sent++;
            c_lo = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            c_hi = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            c_wd = 1'($urandom_range(0, 1));
         end
      end
      check("rand_sent", 64'(n_sent), 64'd1000);
      cyc = 0;
      while (q.size() != 0 && cyc < 50) begin
         step(0, 0, 0, 0, 0, 1);
         cyc++;
      end
      step(0, 0, 0, 0, 0, 1);
      check("rand_rx_len", 64'(rx.size()), 64'(sent.size()));
      for (int i = 0; i < rx.size() && i < sent.size(); i++)
         check("rand_order", rx[i], sent[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
